// File: rtl/klotski_move_sequencer.sv
// ============================================================================
// Module  : klotski_move_sequencer
// Purpose : Turns board-cell move commands into sequential X/Y stepper runs
//           with electromagnet settle, done/error reporting and timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module klotski_move_sequencer #(
  parameter int CELL_STEPS     = 800,
  parameter int SETTLE_CYCLES  = 2500000,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic        i_Clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_col,
  input  logic [2:0]  i_cmd_row,
  input  logic        i_cmd_magnet,
  output logic        o_motor_start,
  output logic        o_motor_axis,
  output logic [14:0] o_motor_steps,
  output logic        o_motor_dir,
  input  logic        i_motor_done,
  output logic        o_magnet,
  output logic [1:0]  o_cur_col,
  output logic [2:0]  o_cur_row,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CHECK   = 4'd1,
    S_SETTLE  = 4'd2,
    S_START_X = 4'd3,
    S_WAIT_X  = 4'd4,
    S_START_Y = 4'd5,
    S_WAIT_Y  = 4'd6,
    S_FIN     = 4'd7
  } state_t;

  localparam logic [14:0] c_cell_steps   = 15'(CELL_STEPS);
  localparam logic [31:0] c_settle_last  = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] c_timeout_last = 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt;
  logic        r_done_d;
  logic [1:0]  r_tgt_col;
  logic [2:0]  r_tgt_row;
  logic        r_tgt_mag;
  logic [14:0] r_steps_x, r_steps_y;
  logic        r_dir_x, r_dir_y;
  logic        r_start, r_done, r_err, r_magnet, r_axis, r_dir;
  logic [14:0] r_steps;
  logic [1:0]  r_cur_col;
  logic [2:0]  r_cur_row;

  logic        w_accept, w_done_rise;
  logic [3:0]  w_dx, w_dy, w_abs_x, w_abs_y;
  logic        w_cnt_clr, w_start_nxt, w_done_nxt, w_err_nxt, w_mag_nxt;
  logic        w_check_load, w_load_x, w_load_y, w_upd_col, w_upd_row;

  assign w_accept    = i_cmd_valid && (r_state == S_IDLE);
  assign w_done_rise = i_motor_done && !r_done_d;

  // Deltas in 4-bit two's complement; magnitude is at most 4 cells.
  assign w_dx    = {2'b00, r_tgt_col} - {2'b00, r_cur_col};
  assign w_dy    = {1'b0, r_tgt_row} - {1'b0, r_cur_row};
  assign w_abs_x = w_dx[3] ? (4'd0 - w_dx) : w_dx;
  assign w_abs_y = w_dy[3] ? (4'd0 - w_dy) : w_dy;

  always_ff @(posedge i_Clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_clr    = 1'b0;
    w_start_nxt  = 1'b0;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_mag_nxt    = r_magnet;
    w_check_load = 1'b0;
    w_load_x     = 1'b0;
    w_load_y     = 1'b0;
    w_upd_col    = 1'b0;
    w_upd_row    = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (r_tgt_row > 3'd4) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_check_load = 1'b1;
          if (r_tgt_mag != r_magnet) begin
            w_mag_nxt   = r_tgt_mag;
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_SETTLE;
          end else begin
            w_state_nxt = S_START_X;
          end
        end
      end
      S_SETTLE: if (r_cnt == c_settle_last) w_state_nxt = S_START_X;
      S_START_X: begin
        if (r_steps_x == 15'd0) begin
          w_state_nxt = S_START_Y;
        end else begin
          w_start_nxt = 1'b1;
          w_load_x    = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_WAIT_X;
        end
      end
      S_WAIT_X: begin
        if (w_done_rise) begin
          w_upd_col   = 1'b1;
          w_state_nxt = S_START_Y;
        end else if (r_cnt == c_timeout_last) begin
          w_err_nxt   = 1'b1;
          w_mag_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      S_START_Y: begin
        if (r_steps_y == 15'd0) begin
          w_state_nxt = S_FIN;
        end else begin
          w_start_nxt = 1'b1;
          w_load_y    = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_WAIT_Y;
        end
      end
      S_WAIT_Y: begin
        if (w_done_rise) begin
          w_upd_row   = 1'b1;
          w_state_nxt = S_FIN;
        end else if (r_cnt == c_timeout_last) begin
          w_err_nxt   = 1'b1;
          w_mag_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      S_FIN: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_rst_n) begin
      r_cnt     <= 32'd0;
      r_done_d  <= 1'b0;
      r_tgt_col <= 2'd0;
      r_tgt_row <= 3'd0;
      r_tgt_mag <= 1'b0;
      r_steps_x <= 15'd0;
      r_steps_y <= 15'd0;
      r_dir_x   <= 1'b0;
      r_dir_y   <= 1'b0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_magnet  <= 1'b0;
      r_axis    <= 1'b0;
      r_steps   <= 15'd0;
      r_dir     <= 1'b0;
      r_cur_col <= 2'd0;
      r_cur_row <= 3'd0;
    end else begin
      r_cnt    <= w_cnt_clr ? 32'd0 : r_cnt + 32'd1;
      r_done_d <= i_motor_done;
      r_start  <= w_start_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_magnet <= w_mag_nxt;
      if (w_accept) begin
        r_tgt_col <= i_cmd_col;
        r_tgt_row <= i_cmd_row;
        r_tgt_mag <= i_cmd_magnet;
      end
      if (w_check_load) begin
        r_steps_x <= 15'(w_abs_x) * c_cell_steps;
        r_steps_y <= 15'(w_abs_y) * c_cell_steps;
        r_dir_x   <= !w_dx[3] && (w_dx != 4'd0);
        r_dir_y   <= !w_dy[3] && (w_dy != 4'd0);
      end
      // Motor command fields only change when a new axis run is launched.
      if (w_load_x) begin
        r_axis  <= 1'b0;
        r_steps <= r_steps_x;
        r_dir   <= r_dir_x;
      end else if (w_load_y) begin
        r_axis  <= 1'b1;
        r_steps <= r_steps_y;
        r_dir   <= r_dir_y;
      end
      if (w_upd_col) r_cur_col <= r_tgt_col;
      if (w_upd_row) r_cur_row <= r_tgt_row;
    end
  end

  assign o_cmd_ready   = (r_state == S_IDLE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_motor_start = r_start;
  assign o_motor_axis  = r_axis;
  assign o_motor_steps = r_steps;
  assign o_motor_dir   = r_dir;
  assign o_magnet      = r_magnet;
  assign o_cur_col     = r_cur_col;
  assign o_cur_row     = r_cur_row;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

`default_nettype wire
